// File: rtl/amba_axi_pkg.sv
// Shared AXI definitions used by the read slave and by the decoder's AXI master blocks.
package amba_axi_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [2:0] SIZE_4B = 3'd2;

    typedef enum logic [1:0] {
        RD_IDLE,
        RD_READ,
        RD_WAIT,
        RD_SEND
    } rd_state_t;

endpackage

// File: rtl/amba_axi_rd_addr_gen.sv
// Beat address and counter for one read burst, with window range check and word-address mapping.
module amba_axi_rd_addr_gen
    import amba_axi_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          MEM_AW    = 10
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              load,
    input  logic              advance,
    input  logic [31:0]       araddr,
    input  logic [3:0]        arlen,
    input  logic [1:0]        arburst,
    output logic [31:0]       addr,
    output logic              last,
    output logic              in_range,
    output logic [MEM_AW-1:0] word_addr
);

    localparam logic [32:0] WINDOW = 33'd4 << MEM_AW;

    logic [3:0]  count;
    logic [1:0]  burst;
    logic        borrow;
    logic [31:0] offset;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            addr  <= '0;
            count <= '0;
            burst <= BURST_FIXED;
        end else if (load) begin
            addr  <= araddr & 32'hFFFF_FFFC;
            count <= arlen;
            burst <= arburst;
        end else if (advance) begin
            count <= count - 4'd1;
            if (burst != BURST_FIXED)
                addr <= addr + 32'd4;
        end
    end

    // A borrow out of the 33-bit subtraction means the beat lies below the window.
    assign {borrow, offset} = {1'b0, addr} - {1'b0, BASE_ADDR};
    assign in_range  = !borrow && ({1'b0, offset} < WINDOW);
    assign word_addr = MEM_AW'(offset >> 2);
    assign last      = (count == 4'd0);

endmodule

// File: rtl/amba_axi_read_slave.sv
// AXI3 read-channel responder: one AR burst at a time, each beat fetched from a
// synchronous word RAM and returned on R with rid/rresp/rlast.
//   state   | meaning
//   IDLE    | arready high, waiting for an AR handshake
//   READ    | memory strobe for the current beat (in-range, supported bursts only)
//   WAIT    | memory data lands; R outputs register at the edge
//   SEND    | rvalid held until rready
module amba_axi_read_slave
    import amba_axi_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          MEM_AW    = 10
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic [3:0]        arid,
    input  logic [31:0]       araddr,
    input  logic [3:0]        arlen,
    input  logic [2:0]        arsize,
    input  logic [1:0]        arburst,
    input  logic [1:0]        arlock,
    input  logic [3:0]        arcache,
    input  logic [2:0]        arprot,
    input  logic              arvalid,
    output logic              arready,
    output logic [3:0]        rid,
    output logic [31:0]       rdata,
    output logic [1:0]        rresp,
    output logic              rlast,
    output logic              rvalid,
    input  logic              rready,
    output logic              mem_en,
    output logic [MEM_AW-1:0] mem_addr,
    input  logic [31:0]       mem_rdata
);

    rd_state_t         state, state_next;
    logic              err;
    logic              ar_hs, r_hs;
    logic              beat_last, beat_in_range, bad_beat;
    logic [31:0]       beat_addr;
    logic [MEM_AW-1:0] word_addr;

    assign ar_hs = arvalid & arready;
    assign r_hs  = rvalid & rready;

    amba_axi_rd_addr_gen #(
        .BASE_ADDR (BASE_ADDR),
        .MEM_AW    (MEM_AW)
    ) u_addr_gen (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .load      (ar_hs),
        .advance   ((state == RD_SEND) && r_hs && !rlast),
        .araddr    (araddr),
        .arlen     (arlen),
        .arburst   (arburst),
        .addr      (beat_addr),
        .last      (beat_last),
        .in_range  (beat_in_range),
        .word_addr (word_addr)
    );

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn)
            state <= RD_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            RD_IDLE: if (ar_hs) state_next = RD_READ;
            RD_READ: state_next = RD_WAIT;
            RD_WAIT: state_next = RD_SEND;
            RD_SEND: if (r_hs) state_next = rlast ? RD_IDLE : RD_READ;
            default: state_next = RD_IDLE;
        endcase
    end

    // Error beats never touch the memory; each beat is range-checked on its own.
    assign bad_beat = err | ~beat_in_range;
    assign mem_en   = (state == RD_READ) && !bad_beat;
    assign mem_addr = mem_en ? word_addr : '0;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            arready <= 1'b0;
            err     <= 1'b0;
            rid     <= '0;
            rdata   <= '0;
            rresp   <= RESP_OKAY;
            rlast   <= 1'b0;
            rvalid  <= 1'b0;
        end else begin
            arready <= (state_next == RD_IDLE);
            if (ar_hs) begin
                rid <= arid;
                err <= (arsize != SIZE_4B) | arburst[1];
            end
            if (state == RD_WAIT) begin
                rdata  <= bad_beat ? 32'h0 : mem_rdata;
                rresp  <= bad_beat ? RESP_SLVERR : RESP_OKAY;
                rlast  <= beat_last;
                rvalid <= 1'b1;
            end else if ((state == RD_SEND) && r_hs) begin
                rvalid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_amba_axi_read_slave.sv
// Directed plus randomized bench for amba_axi_read_slave against a burst-level reference model.
module tb_amba_axi_read_slave;

    localparam logic [31:0] BASE = 32'h0000_0000;
    localparam int          AW   = 10;
    localparam longint      WIN  = 4 * (1 << AW);

    logic          aclk = 1'b0;
    logic          aresetn = 1'b0;
    logic [3:0]    arid = '0;
    logic [31:0]   araddr = '0;
    logic [3:0]    arlen = '0;
    logic [2:0]    arsize = 3'd2;
    logic [1:0]    arburst = 2'b01;
    logic [1:0]    arlock = '0;
    logic [3:0]    arcache = '0;
    logic [2:0]    arprot = '0;
    logic          arvalid = 1'b0;
    logic          arready;
    logic [3:0]    rid;
    logic [31:0]   rdata;
    logic [1:0]    rresp;
    logic          rlast;
    logic          rvalid;
    logic          rready = 1'b1;
    logic          mem_en;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_rdata = '0;

    amba_axi_read_slave #(.BASE_ADDR(BASE), .MEM_AW(AW)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata)
    );

    always #5 aclk = ~aclk;

    logic [31:0]   mem [0:(1<<AW)-1];
    logic [AW-1:0] memq [$];

    always @(posedge aclk) if (mem_en === 1'b1) mem_rdata <= mem[mem_addr];
    always @(negedge aclk) if (mem_en === 1'b1) memq.push_back(mem_addr);

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0]   e_data  [$];
    logic [1:0]    e_resp  [$];
    logic [AW-1:0] e_maddr [$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected beats of a burst, from the address rules alone.
    function automatic void model(input logic [31:0] addr, input logic [3:0] len,
                                  input logic [2:0] size, input logic [1:0] burst);
        logic [31:0] a;
        logic [31:0] off;
        bit bad_req, oor;
        e_data.delete(); e_resp.delete(); e_maddr.delete();
        bad_req = (size != 3'd2) || (burst >= 2'd2);
        for (int i = 0; i <= int'(len); i++) begin
            a = (addr & 32'hFFFF_FFFC) + ((burst == 2'b00) ? 32'd0 : 32'(4 * i));
            oor = (longint'(a) < longint'(BASE)) || (longint'(a) >= longint'(BASE) + WIN);
            if (bad_req || oor) begin
                e_data.push_back(32'h0);
                e_resp.push_back(2'b10);
            end else begin
                off = (a - BASE) >> 2;
                e_data.push_back(mem[off[AW-1:0]]);
                e_resp.push_back(2'b00);
                e_maddr.push_back(off[AW-1:0]);
            end
        end
    endfunction

    task automatic ar_req(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                          input logic [2:0] size, input logic [1:0] burst, output int w);
        arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
        w = 0;
        while (arready !== 1'b1 && w < 50) begin
            @(negedge aclk);
            w++;
        end
        check("ar_handshake_timeout", 64'(w < 50), 64'd1);
        @(posedge aclk);
        #1;
        arvalid = 1'b0;
    endtask

    task automatic rx_burst(input logic [3:0] id, input logic [3:0] len,
                            input int stall_beat, input int stall_n, input int abort_beat);
        int cnt;
        bit busy_ok;
        bit is_last;
        for (int b = 0; b <= int'(len); b++) begin
            cnt = 0;
            busy_ok = 1'b1;
            do begin
                @(negedge aclk);
                cnt++;
                if (arready !== 1'b0) busy_ok = 1'b0;
            end while (rvalid !== 1'b1 && cnt < 20);
            check("arready_busy", 64'(busy_ok), 64'd1);
            check("beat_latency", 64'(cnt), 64'd3);
            if (b == abort_beat) begin
                aresetn = 1'b0;
                #1;
                check("abort_reset_values",
                      {arready, rvalid, rlast, rresp, rid, rdata, mem_en, mem_addr}, 64'd0);
                memq.delete();
                return;
            end
            is_last = (b == int'(len));
            check("rid", rid, id);
            check("rdata", rdata, e_data[b]);
            check("rresp", rresp, e_resp[b]);
            check("rlast", rlast, is_last);
            if (b == stall_beat) begin
                rready = 1'b0;
                repeat (stall_n) begin
                    @(negedge aclk);
                    check("stall_hold", {rvalid, rid, rresp, rlast, rdata},
                          {1'b1, id, e_resp[b], is_last, e_data[b]});
                end
                rready = 1'b1;
            end
            @(posedge aclk);
            #1;
        end
        check("mem_en_count", 64'(memq.size()), 64'(e_maddr.size()));
        for (int i = 0; i < e_maddr.size() && i < memq.size(); i++)
            check("mem_addr", memq[i], e_maddr[i]);
        memq.delete();
    endtask

    task automatic run(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                       input logic [2:0] size, input logic [1:0] burst,
                       input int stall_beat, input int stall_n);
        int w;
        model(addr, len, size, burst);
        ar_req(id, addr, len, size, burst, w);
        rx_burst(id, len, stall_beat, stall_n, -1);
        @(negedge aclk);
        check("arready_reopen", arready, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        logic [31:0] ra;
        logic [2:0]  rs;
        for (int i = 0; i < (1 << AW); i++) mem[i] = $urandom;
        mem[2] = 32'hCAFE_BABE;

        #2;
        check("reset_values", {arready, rvalid, rlast, rresp, rid, rdata, mem_en, mem_addr}, 64'd0);
        repeat (2) @(negedge aclk);
        check("arready_in_reset", arready, 1'b0);
        aresetn = 1'b1;
        @(negedge aclk);
        check("arready_after_reset", arready, 1'b1);

        model(32'h8, 4'd0, 3'd2, 2'b01);
        check("single_beat_model", e_data[0], 32'hCAFE_BABE);
        run(4'd5, 32'h8, 4'd0, 3'd2, 2'b01, -1, 0);

        run(4'd3, 32'h10, 4'd3, 3'd2, 2'b01, 1, 2);
        run(4'd7, 32'h20, 4'd2, 3'd2, 2'b00, -1, 0);
        run(4'd1, BASE + 32'hFF8, 4'd3, 3'd2, 2'b01, 2, 1);
        run(4'd2, 32'h40, 4'd2, 3'd1, 2'b01, -1, 0);
        run(4'd4, 32'h40, 4'd1, 3'd2, 2'b10, -1, 0);
        run(4'd6, 32'hFFFF_FFF8, 4'd3, 3'd2, 2'b01, -1, 0);
        run(4'd9, 32'h33, 4'd1, 3'd2, 2'b01, -1, 0);

        // Reset during beat 2 of a 4-beat burst, then a clean single beat.
        model(32'h100, 4'd3, 3'd2, 2'b01);
        ar_req(4'd8, 32'h100, 4'd3, 3'd2, 2'b01, w);
        rx_burst(4'd8, 4'd3, -1, 0, 1);
        repeat (3) begin
            @(negedge aclk);
            check("held_in_reset", {arready, rvalid, rlast, rresp, rid, rdata, mem_en, mem_addr}, 64'd0);
        end
        aresetn = 1'b1;
        @(negedge aclk);
        check("arready_after_abort", arready, 1'b1);
        run(4'hA, 32'h8, 4'd0, 3'd2, 2'b01, -1, 0);

        // Second request held valid throughout the first burst.
        model(32'h50, 4'd1, 3'd2, 2'b01);
        ar_req(4'hB, 32'h50, 4'd1, 3'd2, 2'b01, w);
        arid = 4'hC; araddr = 32'h60; arlen = 4'd2; arsize = 3'd2; arburst = 2'b01; arvalid = 1'b1;
        rx_burst(4'hB, 4'd1, -1, 0, -1);
        @(negedge aclk);
        check("held_ar_reopen", arready, 1'b1);
        model(32'h60, 4'd2, 3'd2, 2'b01);
        ar_req(4'hC, 32'h60, 4'd2, 3'd2, 2'b01, w);
        check("held_ar_wait", 64'(w), 64'd0);
        rx_burst(4'hC, 4'd2, -1, 0, -1);
        @(negedge aclk);
        check("arready_reopen", arready, 1'b1);

        for (int k = 0; k < 12; k++) begin
            ra = $urandom_range(0, 4200);
            rs = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : 3'd2;
            run(4'($urandom_range(0, 15)), ra, 4'($urandom_range(0, 15)), rs,
                2'($urandom_range(0, 1)), int'($urandom_range(0, 15)), int'($urandom_range(1, 3)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
